// File: rtl/counter_pkg.sv
// Shared constants and helpers for the counter family.
// Mode selectors for SATURATE and a width helper for users sizing counters.
package counter_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Bits needed to hold values 0..value-1 (minimum 1).
    function automatic int clog2(input longint unsigned value);
        int result;
        result = 1;
        for (int i = 1; i < 64; i++) begin
            if ((64'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/counter_toggle_chain.sv
// Combinational T-flip-flop chain: produces q+1 (up) or q-1 (down) modulo 2**WIDTH.
// Bit i toggles when all lower bits are 1 (up) or all 0 (down).
module counter_toggle_chain #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    output logic [WIDTH-1:0] next
);

    // toggle_en[i]: every bit below i is at its carry/borrow value
    logic [WIDTH-1:0] toggle_en;

    assign toggle_en[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign next[gi] = q[gi] ^ toggle_en[gi];
            if (gi < WIDTH - 1) begin : g_carry
                assign toggle_en[gi+1] = toggle_en[gi] & (up ? q[gi] : ~q[gi]);
            end
        end
    endgenerate

endmodule

// File: rtl/counter_updown_n.sv
// Parametrised up/down counter with programmable terminal value, wrap or
// saturate behaviour, parallel load, terminal-count pulse, sticky overflow and compare match.
module counter_updown_n
    import counter_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter int               SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             up,
    input  logic [WIDTH-1:0] cmp,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf,
    output logic             match
);

    localparam logic [WIDTH-1:0] ZERO       = '0;
    localparam bit               FULL_RANGE = (MAX_VAL == {WIDTH{1'b1}});
    localparam bit               SAT_MODE   = (SATURATE == MODE_SAT);

    logic [WIDTH-1:0] q_reg, q_next;
    logic             tc_reg, tc_next;
    logic             ovf_reg, ovf_next;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] load_val;
    logic             at_max, at_zero, boundary;

    counter_toggle_chain #(
        .WIDTH(WIDTH)
    ) u_chain (
        .q   (q_reg),
        .up  (up),
        .next(step_val)
    );

    assign at_max   = (q_reg == MAX_VAL);
    assign at_zero  = (q_reg == ZERO);
    assign boundary = up ? at_max : at_zero;
    assign load_val = (d > MAX_VAL) ? MAX_VAL : d;

    always_comb begin
        q_next   = q_reg;
        tc_next  = 1'b0;
        ovf_next = ovf_reg;
        if (load) begin
            q_next   = load_val;
            ovf_next = 1'b0;
        end else if (en) begin
            tc_next  = boundary;
            ovf_next = ovf_reg | boundary;
            // Over the full binary range the chain wraps on its own.
            if (!boundary || (FULL_RANGE && !SAT_MODE)) begin
                q_next = step_val;
            end else if (SAT_MODE) begin
                q_next = q_reg;
            end else begin
                q_next = up ? ZERO : MAX_VAL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            q_reg   <= '0;
            tc_reg  <= 1'b0;
            ovf_reg <= 1'b0;
        end else begin
            q_reg   <= q_next;
            tc_reg  <= tc_next;
            ovf_reg <= ovf_next;
        end
    end

    assign q     = q_reg;
    assign tc    = tc_reg;
    assign ovf   = ovf_reg;
    assign match = (q_reg == cmp);

endmodule

// File: doc/counter_updown_n.md
# counter_updown_n

Parametrised synchronous up/down counter: the successor to the fixed 8-bit enable counter in the sequential-logic library. Adds configurable width, a programmable terminal value (modulus), wrap or saturate mode, parallel load, direction control, a terminal-count pulse, a sticky overflow flag and a compare-match output. Intended as the general counter primitive for timers, dividers and event counters in later blocks.

## Interface

- `WIDTH`, default 8: counter width in bits; legal range 2..32.
- `MAX_VAL`, default 2**WIDTH-1: terminal value; count range is 0..MAX_VAL; legal range 1..2**WIDTH-1.
- `SATURATE`, default 0: 0 = wrap at boundaries, 1 = hold at boundaries.

Ports:

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `en` in 1: count enable, active high.
- `load` in 1: parallel load strobe, active high.
- `d` in WIDTH: load value.
- `up` in 1: direction; 1 = increment, 0 = decrement.
- `cmp` in WIDTH: compare value.
- `q` out WIDTH: registered count.
- `tc` out 1: registered terminal-count pulse.
- `ovf` out 1: registered sticky overflow/underflow flag.
- `match` out 1: combinational, `q == cmp`.

## Operation

Priority on each rising edge is `reset`, then `load`, then `en`.

- **Reset** (`reset==0`): q=0, tc=0, ovf=0, regardless of `load` and `en`.
- **Load** (`load==1`): q = min(d, MAX_VAL); tc=0; ovf=0. `en` is ignored in that cycle.
- **Count up** (`en==1`, `up==1`):
  - if q<MAX_VAL: q=q+1.
  - if q==MAX_VAL: q=0 when SATURATE=0; q holds at MAX_VAL when SATURATE=1. This is a boundary event.
- **Count down** (`en==1`, `up==0`):
  - if q>0: q=q-1.
  - if q==0: q=MAX_VAL when SATURATE=0; q holds at 0 when SATURATE=1. This is a boundary event.
- **Idle** (`en==0`, no load): q holds; tc=0.

Outputs:

- `tc`: 1 for exactly the cycle following a boundary event; otherwise 0. Under SATURATE=1, tc pulses on every enabled cycle that stays pinned at a boundary.
- `ovf`: set by any boundary event; cleared only by reset or load.
- `match`: valid whenever q is stable; no registering.

Arithmetic:

- All arithmetic is modulo 2**WIDTH internally, but q never leaves 0..MAX_VAL.
- When MAX_VAL = 2**WIDTH-1, increment uses the toggle-chain form: bit i toggles when bits [i-1:0] are all 1 (up) or all 0 (down).
- Otherwise, next value is selected against the MAX_VAL/0 comparison.
- `up` may change on any cycle; the new direction takes effect on the same edge.

## Timing

- Latency from `en`, `load` or `reset` to q: one clock edge.
- tc and ovf update on the same edge as the q update that produced them. Example: q goes MAX_VAL→0 and tc=1 are both visible after edge N.
- match has zero cycle latency from `cmp`. It has a combinational path `cmp`→`match`.
- Reset asserted mid-count takes effect on the next edge. There is no pending state.
- Reset deasserted: counting resumes from 0 on the first edge with `en==1`.
- Simultaneous `load` and `en`: load wins, and no boundary event is recorded.

## Structure

- Shared package `counter_pkg`: constants `MODE_WRAP=0` and `MODE_SAT=1`, plus `function clog2` for derived widths in users.
- One sub-module, `counter_toggle_chain`:
  - combinational; parameter WIDTH; inputs q and up; output next.
  - implements the per-bit T-flip-flop toggle chain.
  - the top level wraps it with boundary, load and saturate muxing and the tc/ovf registers.

## Test plan

1. WIDTH=8, defaults, reset low 2 cycles then en=1, up=1 for 260 cycles → q steps 0..255, wraps to 0 at cycle 256, tc=1 that cycle only, ovf=1 thereafter.
2. WIDTH=4, MAX_VAL=9, SATURATE=0, up=0 from reset → q=0→9→8…; tc and ovf set on the first edge.
3. WIDTH=4, MAX_VAL=9, SATURATE=1:
   - load d=7, then count up 5 cycles → q=8,9,9,9,9; tc=1 on each of the last 3 cycles; ovf=1.
   - a later load d=12 → q=9, ovf=0.
4. load=1 and en=1 together with d=0x40 (WIDTH=8) → q=0x40, tc=0, ovf=0; en=0 afterward → q holds 0x40.
5. Reset asserted while en=1 and q=0x7F → next edge q=0, ovf=0, tc=0, even with load=1 in the same cycle.
6. cmp=0x05, count up from 0 → match=1 only while q=0x05; change cmp to 0x06 while q=0x05 → match drops with no clock edge.
